cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 for the P8 five-stage MIPS pipeline; sits in the M stage directly downstream of the instruction-type decoder.
- Consumes the decoder's mtc0/mfc0/eret classification plus the M-stage PC, branch-delay flag and pipelined exception code.
- Holds SR, Cause, EPC and PrID; raises the interrupt/exception request that flushes the pipeline and redirects fetch to the handler.
- Returns EPC for eret and mfc0 read data.

Parameters:
- PRID_VALUE, 32'h0000_0808, constant returned when PrID (register 15) is read.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a1  in  5  mfc0 read address (instr[15:11] of the M-stage instruction)
- a2  in  5  mtc0 write address (instr[15:11])
- din  in  32  mtc0 write data (forwarded rt value)
- we  in  1  mtc0 in M stage
- exl_clr  in  1  eret in M stage
- pc  in  32  M-stage instruction PC (word aligned)
- bd  in  1  M-stage instruction is in a branch delay slot
- exc_code  in  5  pipelined exception code; 0 = none
- hw_int  in  6  external interrupt lines, level-sensitive
- intreq  out  1  take exception/interrupt this cycle (flush all stages, PC <= 32'h0000_4180)
- epc  out  32  current EPC, used as the eret target
- dout  out  32  mfc0 read data

Behaviour:
- Reset (asynchronous, immediate): SR = 0, Cause = 0, EPC = 0. Outputs then read intreq = 0, epc = 0, dout = 0 (except dout = PRID_VALUE when a1 = 15).
- Register map:
  - 12 SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - 13 Cause: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - 14 EPC: full 32 bits.
  - 15 PrID: constant.
  - Any other address reads 0.
- dout: combinational from current register contents. An mtc0 followed by mfc0 of the same register in the next cycle sees the new value. No same-cycle bypass.
- IP sampling: Cause.IP <= hw_int on every rising edge, regardless of all other inputs. Interrupt detection uses the registered IP, so latency from hw_int assertion to intreq is exactly 1 cycle.
- Request conditions:
  - int_cond = |(IP & IM) & IE & !EXL.
  - exc_cond = (exc_code != 0) & !EXL.
  - intreq = int_cond | exc_cond, combinational.
- On a rising edge with intreq = 1:
  - EXL <= 1.
  - BD <= bd.
  - EPC <= bd ? pc - 4 : pc.
  - ExcCode <= int_cond ? 0 : exc_code. Interrupt has priority over a synchronous exception.
  - A simultaneous mtc0 (we) is discarded; the faulting instruction does not commit.
  - A simultaneous exl_clr is ignored.
- On a rising edge with intreq = 0:
  - exl_clr = 1 sets EXL <= 0.
  - we = 1 writes the addressed register:
    - SR takes din[15:10] into IM, din[1] into EXL, din[0] into IE.
    - EPC takes din fully.
    - Cause, PrID and unmapped addresses are not writable; the write is a no-op.
  - If we (SR) and exl_clr occur in the same cycle, exl_clr wins for EXL only; IM and IE still take din.
- With EXL = 1, all new interrupts and exceptions are masked. The IP bits keep tracking hw_int.
- epc output always equals the EPC register. A write of EPC via mtc0 followed by eret returns to the written value.
- Reset asserted mid-handler clears EXL and all state immediately; intreq drops in the same cycle.

Test Plan:
- Reset then read: assert reset, read a1 = 12/13/14/15 -> dout = 0, 0, 0, 32'h0000_0808; intreq = 0.
- Interrupt: mtc0 SR = 32'h0000_FC01; hw_int = 6'b000100 at edge N -> intreq = 1 after edge N.
  - At edge N+1 with pc = 32'h0000_3010, bd = 0 -> EPC = 32'h0000_3010, Cause = 32'h0000_1000, SR = 32'h0000_FC03, intreq = 0 while EXL = 1.
- Exception in delay slot: exc_code = 5'd10, pc = 32'h0000_3024, bd = 1, SR.EXL = 0 -> intreq = 1 combinationally.
  - Next edge: EPC = 32'h0000_3020, Cause = 32'h8000_0028.
- Priority and masking: hw_int unmasked and exc_code = 5'd4 in the same cycle -> ExcCode = 0.
  - IE = 0 with hw_int active -> intreq stays 0.
  - Cause.IP still reflects hw_int.
- eret: EXL = 1, exl_clr = 1 -> SR.EXL = 0 after the edge; epc unchanged.
  - mtc0 EPC = 32'h0000_3100 then eret -> epc = 32'h0000_3100.
- Write collisions:
  - we to Cause with din = all ones -> Cause unchanged.
  - we to SR in the same cycle as intreq -> SR keeps its pre-exception IM/IE with EXL = 1.
  - Reset asserted while EXL = 1 -> SR = 0 before the next edge.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P8 pipeline: SR, Cause, EPC and PrID, the exception
// and interrupt request, and the mfc0 read path.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0808
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic        exl_clr,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  output logic        intreq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_cond;
  logic        exc_cond;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Request conditions; EXL masks both sources.
  always_comb begin
    int_cond = (|(ip_q & im_q)) & ie_q & ~exl_q;
    exc_cond = (exc_code != 5'd0) & ~exl_q;
    intreq   = int_cond | exc_cond;
  end

  // Next-state: exception entry overrides any mtc0 or eret in the same cycle.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (intreq) begin
      exl_d      = 1'b1;
      bd_d       = bd;
      epc_d      = bd ? (pc - 32'd4) : pc;
      exc_code_d = int_cond ? 5'd0 : exc_code;
    end else begin
      if (we) begin
        case (a2)
          ADDR_SR: begin
            im_d  = din[15:10];
            exl_d = din[1];
            ie_d  = din[0];
          end
          ADDR_EPC: epc_d = din;
          default: ;
        endcase
      end
      // eret placed after the SR write so it wins for EXL only
      if (exl_clr) exl_d = 1'b0;
    end
  end

  // Register state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Architectural register images and mfc0 read mux.
  always_comb begin
    sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    epc        = epc_q;
    case (a1)
      ADDR_SR:    dout = sr_word;
      ADDR_CAUSE: dout = cause_word;
      ADDR_EPC:   dout = epc_q;
      ADDR_PRID:  dout = PRID_VALUE;
      default:    dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, interrupt entry, delay-slot exception,
// priority/masking, eret, and write collisions.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic        exl_clr;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        intreq;
  logic [31:0] epc;
  logic [31:0] dout;

  int unsigned tests_run;
  int unsigned tests_failed;

  cp0_unit #(.PRID_VALUE(32'h0000_0808)) dut (
    .clk      (clk),
    .reset    (reset),
    .a1       (a1),
    .a2       (a2),
    .din      (din),
    .we       (we),
    .exl_clr  (exl_clr),
    .pc       (pc),
    .bd       (bd),
    .exc_code (exc_code),
    .hw_int   (hw_int),
    .intreq   (intreq),
    .epc      (epc),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    a1 = addr;
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; a1 = '0; a2 = '0; din = '0; we = 1'b0; exl_clr = 1'b0;
    pc = '0; bd = 1'b0; exc_code = '0; hw_int = '0;
    #2;
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    rd(5'd15, "rst_prid", 32'h0000_0808);
    rd(5'd3,  "rst_unmapped", 32'h0);
    check("rst_intreq", {31'd0, intreq}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // mtc0 SR: IM all set, IE on
    we = 1'b1; a2 = 5'd12; din = 32'h0000_FC01;
    tick();
    we = 1'b0;
    rd(5'd12, "sr_write", 32'h0000_FC01);

    // interrupt: one cycle latency from hw_int to intreq
    hw_int = 6'b000100;
    #1;
    check("int_latency_pre", {31'd0, intreq}, 32'd0);
    pc = 32'h0000_3010; bd = 1'b0;
    tick();
    check("int_req", {31'd0, intreq}, 32'd1);
    tick();
    check("int_epc", epc, 32'h0000_3010);
    rd(5'd13, "int_cause", 32'h0000_1000);
    rd(5'd12, "int_sr", 32'h0000_FC03);
    check("int_exl_mask", {31'd0, intreq}, 32'd0);

    // drop interrupt while in handler, IP tracks hw_int
    hw_int = 6'b000000;
    tick();
    rd(5'd13, "ip_track_clear", 32'h0);

    // eret
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_FC01);
    check("eret_epc", epc, 32'h0000_3010);
    check("eret_intreq", {31'd0, intreq}, 32'd0);

    // exception in delay slot
    exc_code = 5'd10; pc = 32'h0000_3024; bd = 1'b1;
    #1;
    check("exc_comb", {31'd0, intreq}, 32'd1);
    tick();
    exc_code = 5'd0; bd = 1'b0;
    check("exc_epc", epc, 32'h0000_3020);
    rd(5'd13, "exc_cause", 32'h8000_0028);
    rd(5'd12, "exc_sr", 32'h0000_FC03);

    // exception masked by EXL
    exc_code = 5'd7;
    #1;
    check("exc_masked", {31'd0, intreq}, 32'd0);
    exc_code = 5'd0;

    // mtc0 EPC then eret returns to the written value
    we = 1'b1; a2 = 5'd14; din = 32'h0000_3100;
    tick();
    we = 1'b0;
    rd(5'd14, "epc_write", 32'h0000_3100);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    check("eret_epc_written", epc, 32'h0000_3100);
    rd(5'd12, "eret2_sr", 32'h0000_FC01);

    // Cause is not writable
    we = 1'b1; a2 = 5'd13; din = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    rd(5'd13, "cause_ro", 32'h8000_0028);

    // interrupt beats exception; SR write during intreq discarded
    hw_int = 6'b000001;
    tick();
    check("prio_int", {31'd0, intreq}, 32'd1);
    exc_code = 5'd4; pc = 32'h0000_3040; bd = 1'b0;
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0000;
    tick();
    we = 1'b0; exc_code = 5'd0;
    rd(5'd13, "prio_cause", 32'h0000_0400);
    rd(5'd12, "collide_sr", 32'h0000_FC03);
    check("prio_epc", epc, 32'h0000_3040);

    // IE=0 masks interrupt while IP keeps tracking
    we = 1'b1; a2 = 5'd12; din = 32'h0000_FC00;
    tick();
    we = 1'b0;
    rd(5'd12, "ie0_sr", 32'h0000_FC00);
    check("ie0_masked", {31'd0, intreq}, 32'd0);
    hw_int = 6'b100001;
    tick();
    rd(5'd13, "ip_track", 32'h0000_8400);
    check("ie0_still_masked", {31'd0, intreq}, 32'd0);

    // SR write with eret together: EXL cleared, IM/IE taken
    we = 1'b1; a2 = 5'd12; din = 32'h0000_FC03; exl_clr = 1'b1;
    tick();
    we = 1'b0; exl_clr = 1'b0;
    rd(5'd12, "we_eret_sr", 32'h0000_FC01);
    check("we_eret_intreq", {31'd0, intreq}, 32'd1);
    pc = 32'h0000_3050; bd = 1'b1;
    tick();
    bd = 1'b0;
    check("bd_int_epc", epc, 32'h0000_304C);
    rd(5'd13, "bd_int_cause", 32'h8000_8400);

    // reset mid-handler clears immediately
    reset = 1'b1;
    #1;
    rd(5'd12, "midrst_sr", 32'h0);
    rd(5'd13, "midrst_cause", 32'h0);
    check("midrst_epc", epc, 32'h0);
    check("midrst_intreq", {31'd0, intreq}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
